// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared constants, state encoding and total helpers for the raster sequencer
// Purpose: CEA 1280x720p60 default geometry, IDLE/RUN/DRAIN encoding and the
//          axis-total helper used by video_timing_ctrl and timing_axis.
// Ports:   none (package)
package video_timing_pkg;

   // CEA 1280x720p60 geometry (74.25 MHz pixel clock, 1650x750 totals)
   localparam int H_ACTIVE_720P = 1280;
   localparam int H_FP_720P     = 110;
   localparam int H_SYNC_720P   = 40;
   localparam int H_BP_720P     = 220;
   localparam int V_ACTIVE_720P = 720;
   localparam int V_FP_720P     = 5;
   localparam int V_SYNC_720P   = 5;
   localparam int V_BP_720P     = 20;

   localparam int H_TOTAL_MAX   = 2048;
   localparam int V_TOTAL_MAX   = 1024;

   typedef logic [1:0] state_t;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/video_timing_ctrl_axis.sv
// rtl/video_timing_ctrl_axis.sv - one raster axis: wrapping counter, active window and sync window
// Purpose: counts 0..TOTAL-1 and decodes the active and sync windows from the
//          next count so the registered sync lines up with the registered count.
// Ports:
//   clk, rst_n  pixel clock, asynchronous active-low reset
//   clear       force the next count to 0 (sequencer idle)
//   step        advance the count (wrapping at TOTAL-1)
//   blank       force sync inactive for the next clock
//   count       registered position
//   last        count is at TOTAL-1
//   in_active   next count lies in the active window (unregistered)
//   sync        registered sync output at level POL inside the window
module timing_axis
   import video_timing_pkg::*;
#(
   parameter int WIDTH  = 11,
   parameter int ACTIVE = H_ACTIVE_720P,
   parameter int FP     = H_FP_720P,
   parameter int SYNC   = H_SYNC_720P,
   parameter int BP     = H_BP_720P,
   parameter bit POL    = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             step,
   input  logic             blank,
   output logic [WIDTH-1:0] count,
   output logic             last,
   output logic             in_active,
   output logic             sync
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   // One extra bit so window bounds equal to 2^WIDTH still compare correctly
   localparam logic [WIDTH:0] LAST_C   = (WIDTH+1)'(TOTAL - 1);
   localparam logic [WIDTH:0] ACT_END  = (WIDTH+1)'(ACTIVE);
   localparam logic [WIDTH:0] SYNC_BEG = (WIDTH+1)'(ACTIVE + FP);
   localparam logic [WIDTH:0] SYNC_END = (WIDTH+1)'(ACTIVE + FP + SYNC);

   logic [WIDTH-1:0] nxt;
   logic [WIDTH:0]   nxt_w;
   logic             in_sync;

   assign last = ({1'b0, count} == LAST_C);

   always_comb begin
      nxt = count;
      if (clear) begin
         nxt = '0;
      end else if (step) begin
         nxt = last ? '0 : count + WIDTH'(1);
      end
   end

   assign nxt_w     = {1'b0, nxt};
   assign in_active = (nxt_w < ACT_END);
   assign in_sync   = !blank && (nxt_w >= SYNC_BEG) && (nxt_w < SYNC_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         sync  <= ~POL;
      end else begin
         count <= nxt;
         sync  <= in_sync ? POL : ~POL;
      end
   end

endmodule

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster sequencer driving counters, syncs and de for the HDMI pixel path
// Purpose: scans the display with frame-boundary start/stop and counts frames.
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous reset, active-low
//   enable       run request, level-sensitive
//   counterX     horizontal position (0..H_ACTIVE-1 visible)
//   counterY     vertical position (0..V_ACTIVE-1 visible)
//   hsync        horizontal sync at HS_POL
//   vsync        vertical sync at VS_POL
//   de           data enable (visible pixel)
//   frame_start  one-clock pulse at (0,0) while scanning
//   frame_count  completed frames, wraps at 2^16
module video_timing_ctrl
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_720P,
   parameter int H_FP     = H_FP_720P,
   parameter int H_SYNC   = H_SYNC_720P,
   parameter int H_BP     = H_BP_720P,
   parameter int V_ACTIVE = V_ACTIVE_720P,
   parameter int V_FP     = V_FP_720P,
   parameter int V_SYNC   = V_SYNC_720P,
   parameter int V_BP     = V_BP_720P,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic [10:0] counterX,
   output logic [9:0]  counterY,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   generate
      if (H_TOTAL > H_TOTAL_MAX) begin : g_h_total_err
         $error("video_timing_ctrl: H_TOTAL exceeds 2048");
      end
      if (V_TOTAL > V_TOTAL_MAX) begin : g_v_total_err
         $error("video_timing_ctrl: V_TOTAL exceeds 1024");
      end
   endgenerate

   state_t state, state_nxt;
   logic   running, at_last, blank;
   logic   x_last, y_last, x_in_active, y_in_active;

   assign running = (state != ST_IDLE);
   assign at_last = x_last && y_last;

   // Stop decisions only take effect at the last pixel, so a frame is never cut short
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (enable) state_nxt = ST_RUN;
         ST_RUN:   if (!enable) state_nxt = at_last ? ST_IDLE : ST_DRAIN;
         ST_DRAIN: begin
            if (enable)       state_nxt = ST_RUN;
            else if (at_last) state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Counters show (0,0) in IDLE; blanking hides that position until a run starts
   assign blank = (state_nxt == ST_IDLE);

   timing_axis #(
      .WIDTH(11), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
   ) u_h_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (!running),
      .step      (running),
      .blank     (blank),
      .count     (counterX),
      .last      (x_last),
      .in_active (x_in_active),
      .sync      (hsync)
   );

   // Vertical axis steps on the horizontal wrap, so vsync edges land on X=0
   timing_axis #(
      .WIDTH(10), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
   ) u_v_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (!running),
      .step      (running && x_last),
      .blank     (blank),
      .count     (counterY),
      .last      (y_last),
      .in_active (y_in_active),
      .sync      (vsync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         de          <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_nxt;
         de          <= !blank && x_in_active && y_in_active;
         // Next position is (0,0) when leaving IDLE or wrapping from the last pixel
         frame_start <= !blank && (!running || at_last);
         if (running && at_last) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - scoreboard bench for video_timing_ctrl with a frame-position reference model
module tb_video_timing_ctrl;

   localparam int HA = 16, HFP = 3, HSW = 4, HBP = 5;
   localparam int VA = 10, VFP = 2, VSW = 2, VBP = 3;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FT = HT * VT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b1;

   logic [10:0] cx_p, cx_n;
   logic [9:0]  cy_p, cy_n;
   logic        hs_p, hs_n, vs_p, vs_n, de_p, de_n, fs_p, fs_n;
   logic [15:0] fc_p, fc_n;

   video_timing_ctrl #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut_p (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .counterX(cx_p), .counterY(cy_p), .hsync(hs_p), .vsync(vs_p),
      .de(de_p), .frame_start(fs_p), .frame_count(fc_p)
   );

   video_timing_ctrl #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut_n (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .counterX(cx_n), .counterY(cy_n), .hsync(hs_n), .vsync(vs_n),
      .de(de_n), .frame_start(fs_n), .frame_count(fc_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      bit de;
      bit hs;
      bit vs;
      bit fs;
      int fc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;

   // Reference model: a linear position within the frame plus an idle flag
   int m_pos = 0;
   bit m_idle = 1'b1;
   int m_fc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input bit en);
      if (m_idle) begin
         if (en) begin
            m_idle = 1'b0;
            m_pos  = 0;
         end
      end else if (m_pos == FT - 1) begin
         m_pos = 0;
         m_fc  = (m_fc + 1) % 65536;
         if (!en) m_idle = 1'b1;
      end else begin
         m_pos++;
      end
   endtask

   function automatic exp_t predict();
      exp_t e;
      e.x  = m_idle ? 0 : m_pos % HT;
      e.y  = m_idle ? 0 : m_pos / HT;
      e.de = !m_idle && (e.x < HA) && (e.y < VA);
      e.hs = !m_idle && (e.x >= HA + HFP) && (e.x < HA + HFP + HSW);
      e.vs = !m_idle && (e.y >= VA + VFP) && (e.y < VA + VFP + VSW);
      e.fs = !m_idle && (m_pos == 0);
      e.fc = m_fc;
      return e;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
      model_step(enable);
      q.push_back(predict());
   endtask

   task automatic run_to(input int target);
      int n = 0;
      while (m_idle || m_pos != target) begin
         if (n >= 2 * FT + 10) begin
            chk("run_to_timeout", 32'd0, 32'd1);
            return;
         end
         cycle();
         n++;
      end
   endtask

   task automatic check_reset();
      chk("rst_x_p", cx_p, 0);   chk("rst_y_p", cy_p, 0);
      chk("rst_de_p", de_p, 0);  chk("rst_fs_p", fs_p, 0);
      chk("rst_hs_p", hs_p, 0);  chk("rst_vs_p", vs_p, 0);
      chk("rst_fc_p", fc_p, 0);
      chk("rst_x_n", cx_n, 0);   chk("rst_y_n", cy_n, 0);
      chk("rst_de_n", de_n, 0);  chk("rst_fs_n", fs_n, 0);
      chk("rst_hs_n", hs_n, 1);  chk("rst_vs_n", vs_n, 1);
      chk("rst_fc_n", fc_n, 0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
         end else begin
            e = q.pop_front();
            chk("x_p", cx_p, e.x);         chk("y_p", cy_p, e.y);
            chk("de_p", de_p, e.de);       chk("fs_p", fs_p, e.fs);
            chk("hsync_p", hs_p, e.hs);    chk("vsync_p", vs_p, e.vs);
            chk("fcount_p", fc_p, e.fc);
            chk("x_n", cx_n, e.x);         chk("y_n", cy_n, e.y);
            chk("de_n", de_n, e.de);       chk("fs_n", fs_n, e.fs);
            chk("hsync_n", hs_n, !e.hs);   chk("vsync_n", vs_n, !e.vs);
            chk("fcount_n", fc_n, e.fc);
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      enable = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_reset();
      end
      rst_n = 1'b1;
      cycle();
      mon_en = 1'b1;

      // free run past two frame wraps
      repeat (2 * FT + 50) cycle();

      // stop request mid-frame: frame completes then idles
      run_to(10 * HT + 5);
      enable = 1'b0;
      repeat (FT + 20) cycle();

      // drop and re-raise within one frame: no discontinuity
      enable = 1'b1;
      run_to(3 * HT);
      enable = 1'b0;
      run_to(8 * HT);
      enable = 1'b1;
      repeat (FT) cycle();

      // drop exactly at the last pixel, then restart
      run_to(FT - 1);
      enable = 1'b0;
      repeat (10) cycle();
      enable = 1'b1;
      repeat (5) cycle();

      // random enable toggling
      repeat (4000) begin
         if ($urandom_range(0, 99) < 3) enable = ~enable;
         cycle();
      end

      // asynchronous reset mid-frame with no clock edge
      enable = 1'b1;
      run_to(5 * HT + 8);
      #6;
      mon_en = 1'b0;
      q.delete();
      rst_n = 1'b0;
      #1;
      check_reset();
      m_idle = 1'b1;
      m_pos  = 0;
      m_fc   = 0;
      #20;
      check_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      mon_en = 1'b1;
      repeat (100) cycle();
      #6;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
